gelato_ifetch: RTL and testbench
================================

Name: gelato_ifetch

Overview:
- Instruction fetch unit of the Gelato GPU frontend.
- Acts as the receiving end of the fetch-scheduler→ifetch PC handshake: accepts one (pc, warp_num, split_table_num) request at a time and acknowledges it with a one-cycle caught pulse.
- Fetches the instruction word from the instruction memory/cache port.
- Delivers the instruction plus its warp tags to the decoder over a valid/ready handshake.

Parameters:
- PC_WIDTH, 32, program-counter and memory address width.
- INST_WIDTH, 32, instruction word width.
- WARP_NUM_WIDTH, 5, warp index width.
- SPLIT_NUM_WIDTH, 4, split-table index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, all state and outputs hold
- flush  in  1  abort the in-flight fetch
- pc_valid  in  1  scheduler request valid
- pc_pc  in  PC_WIDTH  request PC
- pc_warp_num  in  WARP_NUM_WIDTH  request warp
- pc_split_table_num  in  SPLIT_NUM_WIDTH  request split entry
- pc_caught  out  1  acceptance pulse to scheduler
- mem_req_valid  out  1  memory read request
- mem_req_addr  out  PC_WIDTH  read address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  INST_WIDTH  instruction word
- dec_valid  out  1  instruction to decoder valid
- dec_ready  in  1  decoder accepts
- dec_inst  out  INST_WIDTH  instruction
- dec_pc  out  PC_WIDTH  instruction PC
- dec_warp_num  out  WARP_NUM_WIDTH  warp
- dec_split_table_num  out  SPLIT_NUM_WIDTH  split entry
- dec_fault  out  1  misaligned-PC fault; present only with GELATO_IFETCH_ALIGN_CHECK_EN

Behaviour:
- Reset: state=IDLE; pc_caught, mem_req_valid, dec_valid, dec_fault, drop_resp = 0; data outputs = 0.
- All transitions below occur only on edges where rdy=1. When rdy=0, the block freezes, including the pc_caught pulse.
- IDLE:
  - If pc_valid && !pc_caught: latch pc/warp/split, set pc_caught<=1, go to REQ.
- pc_caught is high for exactly one cycle, cleared on the next rdy edge.
- The scheduler drops pc_valid on the edge where it samples caught=1, so pc_valid is still high during the caught cycle. The block must not accept that request again; the !pc_caught guard in IDLE and the state change to REQ enforce this.
- REQ:
  - mem_req_valid=1 and mem_req_addr=latched PC, registered.
  - Request transfers on an edge with mem_req_valid && mem_req_ready. Then mem_req_valid<=0 and go to WAIT.
- WAIT:
  - On mem_resp_valid: latch mem_resp_data into dec_inst, set dec_valid<=1 with latched tags, go to OUT.
  - A response in the same cycle as the request transfer is impossible: memory latency is ≥1 cycle.
- OUT:
  - Hold dec_* stable while dec_valid && !dec_ready.
  - On dec_valid && dec_ready: dec_valid<=0, go to IDLE.
- Minimum latency, pc_valid to dec_valid, with zero-wait memory: accept edge, request edge, response edge → dec_valid high 3 cycles after pc_valid is sampled.
- At most one request is in flight. Back-to-back throughput is one instruction per ≥4 cycles.
- flush (takes priority over all other transitions):
  - From any state, go to IDLE and clear dec_valid and mem_req_valid.
  - If flushed in WAIT (request issued, response outstanding), set drop_resp<=1. In IDLE/REQ the next mem_resp_valid is discarded and clears drop_resp. No new request is accepted while drop_resp=1.
  - A pc_caught pulse already issued is not retracted.
- Simultaneous pc_valid and flush in IDLE: flush wins and nothing is accepted.
- Reset mid-operation: asynchronous return to reset values. An outstanding memory response is owned by the memory's own reset.

Optional Feature:
- Macro: GELATO_IFETCH_ALIGN_CHECK_EN.
- Defined:
  - If the latched PC[1:0]≠0, REQ issues no memory request.
  - Go directly to OUT with dec_valid=1, dec_fault=1, dec_inst=0, tags preserved. Aligned PCs give dec_fault=0.
- Undefined:
  - The dec_fault port does not exist.
  - The PC is sent verbatim to memory and no alignment checking is done.

Test Plan:
- pc_valid=1, pc=0x100, warp=3, split=2; memory ready, 1-cycle response 0xDEADBEEF; dec_ready=1 → pc_caught pulses once. mem_req_addr=0x100. dec_valid with inst=0xDEADBEEF, pc=0x100, warp=3, split=2, exactly once.
- pc_valid held high one extra cycle after caught (scheduler behaviour) → only one acceptance and one memory request.
- mem_req_ready low 3 cycles, response delayed 5 cycles, dec_ready low 4 cycles → mem_req_valid and dec_* stay stable, no duplicate request, single delivery.
- flush in WAIT, stale response 0x1111 arrives, then new request pc=0x200 returns 0x2222 → only 0x2222 delivered, with pc=0x200.
- rdy=0 for 3 cycles mid-REQ and mid-OUT → all outputs frozen. Operation resumes identically afterwards.
- With GELATO_IFETCH_ALIGN_CHECK_EN, pc=0x102 → no mem_req_valid. dec_valid with dec_fault=1, dec_inst=0, pc=0x102.

Source files
------------

// File: rtl/gelato_ifetch.sv
// Gelato GPU instruction fetch: takes one PC request at a time, reads the word from
// instruction memory and hands it with its warp tags to the decoder.
// Optional misaligned-PC fault path: define GELATO_IFETCH_ALIGN_CHECK_EN.
module gelato_ifetch #(
    parameter int PC_WIDTH        = 32,
    parameter int INST_WIDTH      = 32,
    parameter int WARP_NUM_WIDTH  = 5,
    parameter int SPLIT_NUM_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       pc_valid,
    input  logic [PC_WIDTH-1:0]        pc_pc,
    input  logic [WARP_NUM_WIDTH-1:0]  pc_warp_num,
    input  logic [SPLIT_NUM_WIDTH-1:0] pc_split_table_num,
    output logic                       pc_caught,
    output logic                       mem_req_valid,
    output logic [PC_WIDTH-1:0]        mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [INST_WIDTH-1:0]      mem_resp_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INST_WIDTH-1:0]      dec_inst,
    output logic [PC_WIDTH-1:0]        dec_pc,
    output logic [WARP_NUM_WIDTH-1:0]  dec_warp_num,
    output logic [SPLIT_NUM_WIDTH-1:0] dec_split_table_num
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    ,
    output logic                       dec_fault
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t                     state, state_next;
    logic [PC_WIDTH-1:0]        lat_pc;
    logic [WARP_NUM_WIDTH-1:0]  lat_warp;
    logic [SPLIT_NUM_WIDTH-1:0] lat_split;
    logic                       drop_resp;
    logic                       accept, req_done, resp_load, out_done, fault_load;
    logic                       accept_issue;
    logic                       resp_owed;

`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    assign accept_issue = (pc_pc[1:0] == 2'b00);
`else
    assign accept_issue = 1'b1;
`endif

    // A flush that lands after the request transferred leaves a response in flight.
    assign resp_owed = (state == WAIT && !mem_resp_valid) ||
                       (state == REQ && mem_req_valid && mem_req_ready);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req_done   = 1'b0;
        resp_load  = 1'b0;
        out_done   = 1'b0;
        fault_load = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_valid && !pc_caught && !drop_resp) begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end
                end
                REQ: begin
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
                    if (lat_pc[1:0] != 2'b00) begin
                        fault_load = 1'b1;
                        state_next = OUT;
                    end else
`endif
                    if (mem_req_valid && mem_req_ready) begin
                        req_done   = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        resp_load  = 1'b1;
                        state_next = OUT;
                    end
                end
                OUT: begin
                    if (dec_valid && dec_ready) begin
                        out_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_caught     <= 1'b0;
            mem_req_valid <= 1'b0;
            dec_valid     <= 1'b0;
            drop_resp     <= 1'b0;
        end else if (rdy) begin
            pc_caught <= accept;

            if (flush)
                mem_req_valid <= 1'b0;
            else if (accept)
                mem_req_valid <= accept_issue;
            else if (req_done)
                mem_req_valid <= 1'b0;

            if (flush)
                dec_valid <= 1'b0;
            else if (resp_load || fault_load)
                dec_valid <= 1'b1;
            else if (out_done)
                dec_valid <= 1'b0;

            if (flush && resp_owed)
                drop_resp <= 1'b1;
            else if (mem_resp_valid)
                drop_resp <= 1'b0;
        end
    end

`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_fault <= 1'b0;
        end else if (rdy) begin
            if (flush || resp_load || out_done)
                dec_fault <= 1'b0;
            else if (fault_load)
                dec_fault <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_pc              <= '0;
            lat_warp            <= '0;
            lat_split           <= '0;
            mem_req_addr        <= '0;
            dec_inst            <= '0;
            dec_pc              <= '0;
            dec_warp_num        <= '0;
            dec_split_table_num <= '0;
        end else if (rdy) begin
            if (accept) begin
                lat_pc       <= pc_pc;
                lat_warp     <= pc_warp_num;
                lat_split    <= pc_split_table_num;
                mem_req_addr <= pc_pc;
            end
            // A faulting fetch still reports its tags, with a zero instruction word.
            if (resp_load || fault_load) begin
                dec_inst            <= resp_load ? mem_resp_data : '0;
                dec_pc              <= lat_pc;
                dec_warp_num        <= lat_warp;
                dec_split_table_num <= lat_split;
            end
        end
    end

endmodule

// File: tb/tb_gelato_ifetch.sv
// Self-checking bench for gelato_ifetch: directed scenarios plus randomized
// transactions against a transaction-level reference model and memory model.
module tb_gelato_ifetch;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush, pc_valid;
    logic [31:0] pc_pc;
    logic [4:0]  pc_warp_num;
    logic [3:0]  pc_split_table_num;
    logic        pc_caught, mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_inst, dec_pc;
    logic [4:0]  dec_warp_num;
    logic [3:0]  dec_split_table_num;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    logic        dec_fault;
`endif

    gelato_ifetch dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .pc_valid(pc_valid), .pc_pc(pc_pc), .pc_warp_num(pc_warp_num),
        .pc_split_table_num(pc_split_table_num), .pc_caught(pc_caught),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_warp_num(dec_warp_num),
        .dec_split_table_num(dec_split_table_num)
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
        , .dec_fault(dec_fault)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: the current request and what it must deliver.
    logic [31:0] tx_pc, exp_inst;
    logic [4:0]  tx_warp;
    logic [3:0]  tx_split;
    logic        tx_req_done, tx_have_inst, tx_mis;
    int caught_cnt = 0, req_cnt = 0, deliv_cnt = 0;
    int pc_drop_delay = 0, drop_wait = 0;

    // Memory / decoder environment.
    int mem_lat = 1, mem_cnt = 0, ready_hold = 0, dec_hold = 0;
    logic mem_pend = 1'b0;
    logic [31:0] data_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        logic [127:0] v;
        v = {pc_caught, mem_req_valid, mem_req_addr, dec_valid, dec_inst, dec_pc,
             dec_warp_num, dec_split_table_num};
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
        v = {v[126:0], dec_fault};
`endif
        return v;
    endfunction

    task automatic tick();
        logic p_rdy, p_caught, p_xfer, p_deliv, p_resp, p_mreq, p_mready, p_dvalid, p_dready;
        p_rdy    = rdy;
        p_caught = pc_caught;
        p_mreq   = mem_req_valid;
        p_mready = mem_req_ready;
        p_dvalid = dec_valid;
        p_dready = dec_ready;
        p_xfer   = mem_req_valid && mem_req_ready && rdy;
        p_deliv  = dec_valid && dec_ready && rdy;
        p_resp   = mem_resp_valid && rdy;
        if (mem_req_valid) chk("mem_req_addr", mem_req_addr, tx_pc);
        if (dec_valid) begin
            chk("dec_after_resp", tx_have_inst, 1'b1);
            chk("dec_inst", dec_inst, exp_inst);
            chk("dec_pc", dec_pc, tx_pc);
            chk("dec_warp", dec_warp_num, tx_warp);
            chk("dec_split", dec_split_table_num, tx_split);
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
            chk("dec_fault", dec_fault, tx_mis);
`endif
        end
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
        if (tx_mis) chk("no_req_misaligned", mem_req_valid, 1'b0);
`endif
        @(posedge clk);
        #1;
        if (p_resp) begin
            if (tx_req_done && !tx_have_inst) begin
                exp_inst     = mem_resp_data;
                tx_have_inst = 1'b1;
            end
            mem_resp_valid = 1'b0;
            mem_pend       = 1'b0;
        end
        if (p_xfer) begin
            req_cnt++;
            tx_req_done = 1'b1;
            mem_pend    = 1'b1;
            mem_cnt     = mem_lat;
        end
        if (drop_wait > 0) begin
            drop_wait--;
            if (drop_wait == 0) pc_valid = 1'b0;
        end
        if (p_caught && p_rdy) begin
            caught_cnt++;
            if (pc_drop_delay == 0) pc_valid = 1'b0;
            else drop_wait = pc_drop_delay;
        end
        if (p_deliv) deliv_cnt++;
        if (p_mreq && !p_mready && p_rdy && ready_hold > 0) ready_hold--;
        if (p_dvalid && !p_dready && p_rdy && dec_hold > 0) dec_hold--;
        mem_req_ready = (ready_hold == 0);
        dec_ready     = (dec_hold == 0);
        if (mem_pend && !mem_resp_valid) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
            end
        end
    endtask

    task automatic set_env(input int lat, input int rh, input int dh);
        mem_lat       = lat;
        ready_hold    = rh;
        dec_hold      = dh;
        mem_req_ready = (rh == 0);
        dec_ready     = (dh == 0);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] w, input logic [3:0] s);
        tx_pc        = pc;
        tx_warp      = w;
        tx_split     = s;
        tx_req_done  = 1'b0;
        tx_have_inst = 1'b0;
        tx_mis       = 1'b0;
        exp_inst     = '0;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) begin
            tx_mis       = 1'b1;
            tx_have_inst = 1'b1;
        end
`endif
        pc_pc              = pc;
        pc_warp_num        = w;
        pc_split_table_num = s;
        pc_valid           = 1'b1;
    endtask

    task automatic wait_deliver(input int budget);
        int start;
        int n;
        start = deliv_cnt;
        n = 0;
        while (deliv_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk("delivered_in_time", deliv_cnt != start, 1'b1);
    endtask

    task automatic freeze3();
        logic [127:0] snap;
        snap = outs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_low_frozen", outs(), snap);
        end
        rdy = 1'b1;
    endtask

    task automatic do_tx(input logic [31:0] pc, input logic [4:0] w, input logic [3:0] s);
        int c0, r0, d0;
        c0 = caught_cnt;
        r0 = req_cnt;
        d0 = deliv_cnt;
        issue(pc, w, s);
        wait_deliver(80);
        tick();
        tick();
        chk("caught_once", caught_cnt - c0, 1);
        chk("req_count", req_cnt - r0, tx_mis ? 0 : 1);
        chk("deliver_once", deliv_cnt - d0, 1);
    endtask

    initial begin
        int c0, r0, d0, n;
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; pc_valid = 1'b0;
        pc_pc = '0; pc_warp_num = '0; pc_split_table_num = '0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        tx_pc = '0; tx_warp = '0; tx_split = '0; exp_inst = '0;
        tx_req_done = 1'b0; tx_have_inst = 1'b0; tx_mis = 1'b0;
        set_env(1, 0, 0);
        tick();
        tick();
        chk("reset_outputs", outs(), 128'd0);
        chk("reset_caught", pc_caught, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic fetch with minimum latency.
        c0 = caught_cnt; r0 = req_cnt; d0 = deliv_cnt;
        data_q.push_back(32'hDEADBEEF);
        issue(32'h100, 5'd3, 4'd2);
        tick();
        chk("t1_caught", pc_caught, 1'b1);
        chk("t1_req_valid", mem_req_valid, 1'b1);
        chk("t1_req_addr", mem_req_addr, 32'h100);
        tick();
        chk("t1_not_early", dec_valid, 1'b0);
        tick();
        chk("t1_latency3", dec_valid, 1'b1);
        chk("t1_inst", dec_inst, 32'hDEADBEEF);
        wait_deliver(10);
        tick(); tick();
        chk("t1_caught_once", caught_cnt - c0, 1);
        chk("t1_req_once", req_cnt - r0, 1);
        chk("t1_deliver_once", deliv_cnt - d0, 1);

        // Scheduler keeps pc_valid an extra cycle past the catch.
        pc_drop_delay = 1;
        do_tx(32'h0000_0A40, 5'd17, 4'd9);
        pc_drop_delay = 0;

        // Stalled memory request, slow response, stalled decoder.
        set_env(5, 3, 4);
        do_tx(32'h0000_1234, 5'd30, 4'd15);

        // Flush while the response is outstanding.
        set_env(3, 0, 0);
        data_q.push_back(32'h1111);
        data_q.push_back(32'h2222);
        c0 = caught_cnt; r0 = req_cnt; d0 = deliv_cnt;
        issue(32'h300, 5'd1, 4'd1);
        n = 0;
        while (req_cnt == r0 && n < 20) begin tick(); n++; end
        chk("flush_req_sent", req_cnt - r0, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_clears_dec", dec_valid, 1'b0);
        chk("flush_clears_req", mem_req_valid, 1'b0);
        set_env(1, 0, 0);
        issue(32'h200, 5'd7, 4'd5);
        wait_deliver(40);
        chk("flush_new_inst", exp_inst, 32'h2222);
        tick(); tick();
        chk("flush_caught_total", caught_cnt - c0, 2);
        chk("flush_deliver_total", deliv_cnt - d0, 1);

        // Flush together with a new request in IDLE: nothing is accepted.
        c0 = caught_cnt;
        flush = 1'b1;
        issue(32'h440, 5'd2, 4'd3);
        tick();
        chk("flush_idle_no_catch", pc_caught, 1'b0);
        flush = 1'b0;
        wait_deliver(20);
        tick(); tick();
        chk("flush_idle_caught_once", caught_cnt - c0, 1);

        // rdy low mid-REQ (during the caught pulse) and mid-OUT.
        set_env(2, 0, 3);
        c0 = caught_cnt; r0 = req_cnt; d0 = deliv_cnt;
        issue(32'h180, 5'd11, 4'd6);
        tick();
        chk("frz_in_req", mem_req_valid, 1'b1);
        freeze3();
        n = 0;
        while (!dec_valid && n < 20) begin tick(); n++; end
        chk("frz_reached_out", dec_valid, 1'b1);
        freeze3();
        wait_deliver(20);
        tick(); tick();
        chk("frz_caught_once", caught_cnt - c0, 1);
        chk("frz_req_once", req_cnt - r0, 1);
        chk("frz_deliver_once", deliv_cnt - d0, 1);

`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
        set_env(1, 0, 0);
        do_tx(32'h102, 5'd4, 4'd8);
        do_tx(32'h104, 5'd5, 4'd9);
`endif

        // Randomized transactions.
        for (int i = 0; i < 24; i++) begin
            set_env($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            do_tx($urandom, 5'($urandom), 4'($urandom));
        end

        // Asynchronous reset in the middle of a fetch.
        set_env(4, 0, 0);
        issue(32'h5000, 5'd9, 4'd4);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 128'd0);
        pc_valid = 1'b0;
        mem_pend = 1'b0;
        mem_resp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_env(1, 0, 0);
        do_tx(32'h6000, 5'd21, 4'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
